xy_scan_gen: RTL and testbench

Parametrised XY scan generator for the BNC oscilloscope outputs. It is the successor to the fixed free-running X/Y counter. It produces registered X/Y coordinates in four selectable scan modes, with a programmable dwell per point, a frame trigger pulse, a blanking flag and a frame counter. It sits beside the VGA image generator, and its outputs feed the BNC PMOD bit-mapping in the top level.

---
 rtl/xy_scan_pkg.sv | 15 +
 rtl/xy_tick_prescaler.sv | 31 +++
 rtl/xy_scan_gen.sv | 146 ++++++++++++++
 tb/tb_xy_scan_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/xy_scan_pkg.sv
// Shared types and constants for the XY scan generator.
package xy_scan_pkg;

   // Scan mode encoding as seen on the mode input.
   typedef enum logic [1:0] {
      MODE_RASTER = 2'd0,
      MODE_SERP   = 2'd1,
      MODE_TRI    = 2'd2,
      MODE_HOLD   = 2'd3
   } scan_mode_t;

   // Width of the frame counter output.
   localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/xy_tick_prescaler.sv
// Dwell prescaler: issues one step every div+1 enabled cycles.
module xy_tick_prescaler #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             step
);

   logic [DIV_W-1:0] p;

   // The >= test lets a lowered div take effect at once instead of
   // waiting for p to wrap around.
   assign step = enable && (p >= div);

   // Count enabled cycles, restarting on every step.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch
      // and the sensitivity list holds only the clock edge.
      if (!rst_n) begin
         p <= '0;
      end else if (step) begin
         p <= '0;
      end else if (enable) begin
         p <= p + 1'b1;
      end
   end

endmodule

// File: rtl/xy_scan_gen.sv
// XY scan generator for the oscilloscope outputs: raster, serpentine,
// triangle and hold scans with programmable dwell, frame trigger,
// blanking and frame counter.
module xy_scan_gen
   import xy_scan_pkg::*;
#(
   parameter int XW    = 8,
   parameter int YW    = 7,
   parameter int DIV_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic [DIV_W-1:0]       div,
   output logic [XW-1:0]          x_out,
   output logic [YW-1:0]          y_out,
   output logic                   trig,
   output logic                   blank,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam logic [XW-1:0] X_MAX = '1;
   localparam logic [YW-1:0] Y_MAX = '1;

   scan_mode_t        mode_req;
   scan_mode_t        mode_act;
   scan_mode_t        mode_nx;
   logic              step;
   logic              dir_x_up;
   logic              dir_y_up;
   logic [XW-1:0]     x_nx;
   logic [YW-1:0]     y_nx;
   logic              dx_nx;
   logic              dy_nx;
   logic              frame_end;

   assign mode_req = scan_mode_t'(mode);

   // HOLD follows the requested mode on every step; other modes switch
   // only when their frame ends.
   assign mode_nx = (frame_end || mode_act == MODE_HOLD) ? mode_req : mode_act;

   xy_tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .div    (div),
      .step   (step)
   );

   // Next position for the active mode, assuming a step happens now.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      x_nx      = x_out;
      y_nx      = y_out;
      dx_nx     = dir_x_up;
      dy_nx     = dir_y_up;
      frame_end = 1'b0;
      case (mode_act)
         MODE_RASTER: begin
            if (x_out == X_MAX) begin
               x_nx      = '0;
               y_nx      = y_out + 1'b1;
               frame_end = (y_out == Y_MAX);
            end else begin
               x_nx = x_out + 1'b1;
            end
         end
         MODE_SERP: begin
            if (y_out[0] ? (x_out == '0) : (x_out == X_MAX)) begin
               y_nx      = y_out + 1'b1;
               frame_end = (y_out == Y_MAX);
            end else if (y_out[0]) begin
               x_nx = x_out - 1'b1;
            end else begin
               x_nx = x_out + 1'b1;
            end
         end
         MODE_TRI: begin
            if (dir_x_up && x_out == X_MAX) begin
               dx_nx = 1'b0;
               x_nx  = x_out - 1'b1;
            end else if (!dir_x_up && x_out == '0) begin
               dx_nx = 1'b1;
               x_nx  = x_out + 1'b1;
            end else begin
               x_nx = dir_x_up ? x_out + 1'b1 : x_out - 1'b1;
            end
            if (dir_y_up && y_out == Y_MAX) begin
               dy_nx = 1'b0;
               y_nx  = y_out - 1'b1;
            end else if (!dir_y_up && y_out == '0) begin
               dy_nx = 1'b1;
               y_nx  = y_out + 1'b1;
            end else begin
               y_nx = dir_y_up ? y_out + 1'b1 : y_out - 1'b1;
            end
            frame_end = (x_nx == '0) && !dx_nx;
         end
         default: ;
      endcase
   end

   // Register position, mode, trigger, blanking and frame count on steps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_out     <= '0;
         y_out     <= '0;
         dir_x_up  <= 1'b1;
         dir_y_up  <= 1'b1;
         mode_act  <= MODE_RASTER;
         trig      <= 1'b0;
         blank     <= 1'b1;
         frame_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignment throughout; the default below is
         // overridden later in the same block only on a frame start.
         trig <= 1'b0;
         if (step) begin
            mode_act <= mode_nx;
            if (frame_end) begin
               // Entering HOLD parks the beam at the origin without
               // starting a frame.
               x_out    <= '0;
               y_out    <= '0;
               dir_x_up <= 1'b1;
               dir_y_up <= 1'b1;
               trig     <= (mode_req != MODE_HOLD);
               blank    <= (mode_req != MODE_HOLD);
               if (mode_req != MODE_HOLD) begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end else begin
               x_out    <= x_nx;
               y_out    <= y_nx;
               dir_x_up <= dx_nx;
               dir_y_up <= dy_nx;
               blank    <= (mode_nx == MODE_RASTER) && (x_nx == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_xy_scan_gen.sv
// Scoreboard bench for xy_scan_gen: a point-index reference model predicts
// each cycle's outputs; a monitor compares them after every clock edge.
module tb_xy_scan_gen;

   localparam int XW    = 2;
   localparam int YW    = 2;
   localparam int DIV_W = 4;
   localparam int W     = 1 << XW;
   localparam int H     = 1 << YW;
   localparam int XM    = W - 1;
   localparam int YM    = H - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [DIV_W-1:0] div = '0;
   logic [XW-1:0]    x_out;
   logic [YW-1:0]    y_out;
   logic             trig;
   logic             blank;
   logic [7:0]       frame_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int x;
      int y;
      int trig;
      int blank;
      int fcnt;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state: active mode and index of the point in its frame.
   int m_mode  = 0;
   int m_k     = 0;
   int m_p     = 0;
   int m_trig  = 0;
   int m_blank = 1;
   int m_fcnt  = 0;
   int m_first = 0;

   xy_scan_gen #(.XW(XW), .YW(YW), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .mode      (mode),
      .div       (div),
      .x_out     (x_out),
      .y_out     (y_out),
      .trig      (trig),
      .blank     (blank),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int frame_len(input int md);
      return (md == 2) ? 2 * XM : W * H;
   endfunction

   // Coordinates of point k of a frame, straight from the scan shapes.
   task automatic pos(input int md, input int k, output int x, output int y);
      int r;
      case (md)
         0: begin
            x = k % W;
            y = k / W;
         end
         1: begin
            y = k / W;
            x = (y % 2 == 0) ? k % W : XM - k % W;
         end
         2: begin
            x = (k <= XM) ? k : 2 * XM - k;
            r = k % (2 * YM);
            y = (r <= YM) ? r : 2 * YM - r;
         end
         default: begin
            x = 0;
            y = 0;
         end
      endcase
   endtask

   // Advance the model by one clock edge with the given inputs.
   task automatic model_edge(input bit rst, input bit en, input int md, input int dv);
      int x, y;
      if (!rst) begin
         m_mode = 0; m_k = 0; m_p = 0; m_trig = 0; m_blank = 1; m_fcnt = 0;
      end else if (!en) begin
         m_trig = 0;
      end else if (m_p < dv) begin
         m_p++;
         m_trig = 0;
      end else begin
         m_p = 0;
         m_first = 0;
         m_trig = 0;
         if (m_mode == 3) begin
            m_mode = md;
         end else if (m_k == frame_len(m_mode) - 1) begin
            m_mode = md;
            m_k = 0;
            if (md != 3) begin
               m_trig = 1;
               m_first = 1;
               m_fcnt = (m_fcnt + 1) % 256;
            end
         end else begin
            m_k++;
         end
         pos(m_mode, m_k, x, y);
         if (m_mode == 0) m_blank = (x == 0) ? 1 : 0;
         else if (m_mode == 3) m_blank = 0;
         else m_blank = m_first;
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic drive(input bit rst, input bit en, input int md, input int dv);
      exp_t e;
      @(negedge clk);
      rst_n  = rst;
      enable = en;
      mode   = md[1:0];
      div    = dv[DIV_W-1:0];
      model_edge(rst, en, md, dv);
      pos(m_mode, m_k, e.x, e.y);
      e.trig  = m_trig;
      e.blank = m_blank;
      e.fcnt  = m_fcnt;
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs shortly after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("x_out", 32'(x_out), e.x);
            check("y_out", 32'(y_out), e.y);
            check("trig", 32'(trig), e.trig);
            check("blank", 32'(blank), e.blank);
            check("frame_cnt", 32'(frame_cnt), e.fcnt);
         end
      end
   end

   // Stimulus: directed phases from the test plan, then random traffic.
   initial begin
      int md = 0;
      int dv = 0;
      bit en;
      bit rst;
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
      for (int i = 0; i < 40; i++) drive(1, 1, 0, 0);      // raster basic
      for (int i = 0; i < 20; i++) drive(1, 1, 0, 3);      // dwell of 4
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 3);
      drive(1, 1, 0, 0);                                   // div lowered mid-count
      for (int i = 0; i < 40; i++) drive(1, 1, 1, 0);      // serpentine
      for (int i = 0; i < 30; i++) drive(1, 1, 2, 0);      // switch to triangle
      for (int i = 0; i < 20; i++) drive(1, 1, 0, 0);
      for (int i = 0; i < 30; i++) drive(1, 1, 3, 0);      // hold
      for (int i = 0; i < 20; i++) drive(1, 1, 0, 0);      // resume raster
      for (int i = 0; i < 10; i++) drive(1, 0, 0, 0);      // enable low
      for (int i = 0; i < 6; i++) drive(1, 1, 0, 0);
      drive(0, 1, 0, 0);                                   // reset mid-frame
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) md = $urandom_range(3);
         if ($urandom_range(29) == 0) dv = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(2);
         en  = ($urandom_range(7) != 0);
         rst = ($urandom_range(499) != 0);
         drive(rst, en, md, dv);
      end
      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
